// File: rtl/display_mode_ctrl_if.sv
// Key, vsync and display-select bundle between the key pins,
// the display multiplexer and display_mode_ctrl.
interface display_mode_ctrl_if;
  logic       key_next_n;
  logic       key_prev_n;
  logic       key_auto_n;
  logic       vs_in;
  logic [1:0] mode_sel;
  logic       mode_pending;
  logic       out_blank;
  logic       auto_on;

  modport master (
    output key_next_n,
    output key_prev_n,
    output key_auto_n,
    output vs_in,
    input  mode_sel,
    input  mode_pending,
    input  out_blank,
    input  auto_on
  );

  modport slave (
    input  key_next_n,
    input  key_prev_n,
    input  key_auto_n,
    input  vs_in,
    output mode_sel,
    output mode_pending,
    output out_blank,
    output auto_on
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// Frame-synchronous display-source sequencer: debounced keys,
// vsync-aligned mode switching and post-switch blanking.
module display_mode_ctrl #(
  parameter int NUM_MODES    = 3,
  parameter int DEBOUNCE_CNT = 500000,
  parameter int BLANK_FRAMES = 1,
  parameter int AUTO_FRAMES  = 120
) (
  input logic               vga_clk,
  input logic               sys_rst_n,
  display_mode_ctrl_if.slave bus
);
  localparam int DCW = $clog2(DEBOUNCE_CNT);
  localparam int AFW = AUTO_FRAMES > 1 ? $clog2(AUTO_FRAMES) : 1;
  localparam int BFW = BLANK_FRAMES > 1 ? $clog2(BLANK_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, PENDING, BLANK} state_t;

  logic [2:0]     key_raw;
  logic [2:0]     sync1, sync2, stable, press;
  logic [DCW-1:0] dcnt [3];

  logic           vs_q, fs;
  logic           auto_q, auto_step, key_step;
  logic           do_next, do_prev;
  logic [AFW-1:0] fcnt;
  logic [1:0]     target_q, target_nxt;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic           blank_q, blank_d;
  logic           pend_q;
  logic [BFW-1:0] bcnt_q, bcnt_d;

  assign key_raw = {bus.key_auto_n, bus.key_prev_n, bus.key_next_n};

  // index 0 next, 1 prev, 2 auto
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      stable <= '1;
      press  <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DCW'(DEBOUNCE_CNT - 1)) begin
          stable[i] <= sync2[i];
          dcnt[i]   <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fs        = vs_q & ~bus.vs_in;
  assign key_step  = press[0] ^ press[1];
  assign auto_step = auto_q & fs & (fcnt == AFW'(AUTO_FRAMES - 1));
  assign do_next   = key_step ? press[0] : auto_step;
  assign do_prev   = key_step & press[1];

  always_comb begin
    target_nxt = target_q;
    if (do_next)
      target_nxt = (target_q == 2'(NUM_MODES - 1)) ? 2'd0 : target_q + 2'd1;
    else if (do_prev)
      target_nxt = (target_q == 2'd0) ? 2'(NUM_MODES - 1) : target_q - 2'd1;
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      vs_q     <= 1'b1;
      auto_q   <= 1'b0;
      fcnt     <= '0;
      target_q <= '0;
    end else begin
      vs_q     <= bus.vs_in;
      auto_q   <= auto_q ^ press[2];
      target_q <= target_nxt;
      if ((press[2] & auto_q) | key_step)
        fcnt <= '0;
      else if (auto_q & fs)
        fcnt <= auto_step ? '0 : fcnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (target_nxt != mode_q) state_d = PENDING;
      end
      PENDING: begin
        if (fs && target_q != mode_q) begin
          mode_d = target_q;
          if (BLANK_FRAMES > 0) begin
            blank_d = 1'b1;
            bcnt_d  = '0;
            state_d = BLANK;
          end else begin
            state_d = IDLE;
          end
        end else if (target_nxt == mode_q) begin
          state_d = IDLE;
        end
      end
      BLANK: begin
        // the fs that ends blanking never switches; a new request waits
        if (fs) begin
          if (bcnt_q == BFW'(BLANK_FRAMES - 1)) begin
            blank_d = 1'b0;
            state_d = (target_nxt != mode_q) ? PENDING : IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      blank_q <= 1'b0;
      bcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= (state_d != IDLE);
    end
  end

  assign bus.mode_sel     = mode_q;
  assign bus.mode_pending = pend_q;
  assign bus.out_blank    = blank_q;
  assign bus.auto_on      = auto_q;
endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl: debounce, frame alignment,
// wrap, cancel, auto-cycle, blanking and reset.
module tb_display_mode_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  display_mode_ctrl_if bus ();

  display_mode_ctrl #(
    .NUM_MODES   (3),
    .DEBOUNCE_CNT(4),
    .BLANK_FRAMES(2),
    .AUTO_FRAMES (3)
  ) dut (
    .vga_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one frame: vsync low for one sampled edge, then high
  task automatic frame();
    bus.vs_in = 1'b0;
    tick(1);
    bus.vs_in = 1'b1;
    tick(3);
  endtask

  task automatic press(input int k);
    if (k == 0) bus.key_next_n = 1'b0;
    if (k == 1) bus.key_prev_n = 1'b0;
    if (k == 2) bus.key_auto_n = 1'b0;
    tick(10);
    bus.key_next_n = 1'b1;
    bus.key_prev_n = 1'b1;
    bus.key_auto_n = 1'b1;
    tick(10);
  endtask

  initial begin
    bus.key_next_n = 1'b1;
    bus.key_prev_n = 1'b1;
    bus.key_auto_n = 1'b1;
    bus.vs_in      = 1'b1;
    rst_n          = 1'b0;
    tick(3);
    chk("rst_mode", bus.mode_sel, 0);
    chk("rst_pend", bus.mode_pending, 0);
    chk("rst_blank", bus.out_blank, 0);
    chk("rst_auto", bus.auto_on, 0);
    rst_n = 1'b1;
    tick(2);

    bus.key_next_n = 1'b0;
    tick(3);
    bus.key_next_n = 1'b1;
    tick(10);
    chk("glitch_target", dut.target_q, 0);
    chk("glitch_pend", bus.mode_pending, 0);

    bus.key_next_n = 1'b0;
    tick(5);
    chk("pulse_early", dut.press, 0);
    tick(1);
    chk("pulse_edge6", dut.press, 8'h01);
    tick(1);
    chk("pulse_single", dut.press, 0);
    chk("step_target", dut.target_q, 1);
    chk("step_pend", bus.mode_pending, 1);
    bus.key_next_n = 1'b1;
    tick(10);
    chk("wait_fs", bus.mode_sel, 0);

    bus.vs_in = 1'b0;
    tick(1);
    chk("fs_switch", bus.mode_sel, 1);
    chk("fs_blank", bus.out_blank, 1);
    bus.vs_in = 1'b1;
    tick(3);
    frame();
    chk("blank_f2", bus.out_blank, 1);
    chk("pend_f2", bus.mode_pending, 1);
    frame();
    chk("blank_end", bus.out_blank, 0);
    chk("pend_end", bus.mode_pending, 0);

    press(0);
    frame();
    chk("to2", bus.mode_sel, 2);
    frame();
    frame();
    press(0);
    chk("wrap_target", dut.target_q, 0);
    frame();
    chk("wrap_mode", bus.mode_sel, 0);
    frame();
    frame();
    press(1);
    chk("prev_target", dut.target_q, 2);
    frame();
    chk("prev_wrap", bus.mode_sel, 2);
    frame();
    frame();
    press(0);
    frame();
    frame();
    frame();
    press(0);
    press(0);
    chk("acc_target", dut.target_q, 2);
    chk("acc_hold", bus.mode_sel, 0);
    frame();
    chk("acc_jump", bus.mode_sel, 2);
    frame();
    frame();
    chk("acc_idle", bus.mode_pending, 0);

    press(0);
    frame();
    chk("rb_sw", bus.mode_sel, 0);
    chk("rb_blank", bus.out_blank, 1);
    press(0);
    chk("rb_target", dut.target_q, 1);
    frame();
    chk("rb_f2", bus.mode_sel, 0);
    frame();
    chk("rb_end_mode", bus.mode_sel, 0);
    chk("rb_end_blank", bus.out_blank, 0);
    chk("rb_end_pend", bus.mode_pending, 1);
    frame();
    chk("rb_switch", bus.mode_sel, 1);
    frame();
    frame();

    bus.key_next_n = 1'b0;
    bus.key_prev_n = 1'b0;
    tick(10);
    bus.key_next_n = 1'b1;
    bus.key_prev_n = 1'b1;
    tick(10);
    chk("simul_target", dut.target_q, 1);
    chk("simul_pend", bus.mode_pending, 0);

    press(0);
    chk("cancel_pend_on", bus.mode_pending, 1);
    press(1);
    chk("cancel_pend_off", bus.mode_pending, 0);
    frame();
    chk("cancel_mode", bus.mode_sel, 1);
    chk("cancel_blank", bus.out_blank, 0);

    press(2);
    chk("auto_on", bus.auto_on, 1);
    frame();
    frame();
    chk("auto_hold", bus.mode_sel, 1);
    chk("auto_hold_pend", bus.mode_pending, 0);
    frame();
    chk("auto_step_target", dut.target_q, 2);
    frame();
    chk("auto_m2", bus.mode_sel, 2);
    frame();
    frame();
    frame();
    chk("auto_m0", bus.mode_sel, 0);
    frame();
    frame();
    frame();
    chk("auto_m1", bus.mode_sel, 1);
    frame();
    press(0);
    chk("restart_press", dut.target_q, 2);
    frame();
    chk("restart_target", dut.target_q, 2);
    frame();
    chk("restart_mode", bus.mode_sel, 2);
    frame();
    chk("restart_step", dut.target_q, 0);
    press(2);
    chk("auto_off", bus.auto_on, 0);
    frame();
    frame();
    frame();
    frame();
    chk("auto_last", bus.mode_sel, 0);
    frame();
    frame();
    frame();
    frame();
    chk("auto_stop_target", dut.target_q, 0);
    chk("auto_stop_mode", bus.mode_sel, 0);
    chk("auto_stop_pend", bus.mode_pending, 0);

    press(0);
    frame();
    chk("rst_pre_mode", bus.mode_sel, 1);
    chk("rst_pre_blank", bus.out_blank, 1);
    rst_n = 1'b0;
    tick(1);
    chk("rstb_mode", bus.mode_sel, 0);
    chk("rstb_blank", bus.out_blank, 0);
    chk("rstb_pend", bus.mode_pending, 0);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
